// File: rtl/instruction_fetch.sv
// Fetch stage: loadable program memory, PC and a single-entry
// registered instruction output with a valid/ready handshake.
module instruction_fetch #(
    parameter int          ADDR_W      = 8,
    parameter logic [7:0]  HALT_OPCODE = 8'hFF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_en,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [7:0]        load_data,
    input  logic              run,
    input  logic              jump_en,
    input  logic [ADDR_W-1:0] jump_addr,
    input  logic              out_ready,
    output logic [7:0]        instruction,
    output logic              instr_valid,
    output logic [ADDR_W-1:0] instr_pc,
    output logic              halted,
    output logic              busy
);

    localparam int              DEPTH  = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] PC_ONE = ADDR_W'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    state_t            state_q;
    logic [ADDR_W-1:0] pc_q;
    logic [7:0]        instr_q;
    logic              valid_q;
    logic [ADDR_W-1:0] ipc_q;
    logic              halted_q;
    logic              busy_q;

    logic [7:0]        mem_q [DEPTH];
    logic [7:0]        fetch_word;
    logic              transfer;
    logic              advance;
    logic              drained;

    assign fetch_word = mem_q[pc_q];
    assign transfer   = valid_q & out_ready;
    assign advance    = (state_q == RUN) & run
                      & (~valid_q | out_ready) & ~jump_en;
    // Held entry is gone now or leaves at this edge.
    assign drained    = ~valid_q | transfer;

    // Program memory: written only while idle, never cleared.
    always_ff @(posedge clk) begin
        if (load_en && state_q == IDLE && !rst) begin
            mem_q[load_addr] <= load_data;
        end
    end

    // Fetch control FSM with registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            pc_q     <= '0;
            instr_q  <= 8'h00;
            valid_q  <= 1'b0;
            ipc_q    <= '0;
            halted_q <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (run) begin
                        state_q  <= RUN;
                        busy_q   <= 1'b1;
                        halted_q <= 1'b0;
                    end
                end
                RUN: begin
                    if (jump_en) begin
                        pc_q    <= jump_addr;
                        valid_q <= 1'b0;
                    end else if (advance) begin
                        instr_q <= fetch_word;
                        ipc_q   <= pc_q;
                        valid_q <= 1'b1;
                        pc_q    <= pc_q + PC_ONE;
                        if (fetch_word == HALT_OPCODE) begin
                            state_q  <= HALT;
                            busy_q   <= 1'b0;
                            halted_q <= 1'b1;
                        end
                    end else begin
                        if (transfer) begin
                            valid_q <= 1'b0;
                        end
                        if (!run && drained) begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                        end
                    end
                end
                HALT: begin
                    if (transfer) begin
                        valid_q <= 1'b0;
                    end
                    if (!run && drained) begin
                        state_q  <= IDLE;
                        halted_q <= 1'b0;
                    end
                end
                default: begin
                    state_q  <= IDLE;
                    busy_q   <= 1'b0;
                    halted_q <= 1'b0;
                end
            endcase
        end
    end

    assign instruction = instr_q;
    assign instr_valid = valid_q;
    assign instr_pc    = ipc_q;
    assign halted      = halted_q;
    assign busy        = busy_q;

endmodule

// File: doc/instruction_fetch.md
Name: instruction_fetch

Overview:
- Fetch stage directly upstream of `instruction_decoder`.
- Holds a small loadable program memory and a program counter (PC).
- Delivers one 8-bit instruction per accepted transfer to the decoder over a valid/ready handshake.
- Supports program load while idle, jumps, wrap-around and a halt opcode.

Parameters:
- ADDR_W, 8, PC and memory address width; memory depth = 2**ADDR_W.
- HALT_OPCODE, 8'hFF, instruction value that stops fetching after it is delivered.

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- load_en  in  1  write load_data to mem[load_addr]; honoured only in IDLE
- load_addr  in  ADDR_W  program load address
- load_data  in  8  program load data
- run  in  1  level; high starts/continues fetching
- jump_en  in  1  one-cycle pulse; redirect PC (RUN only)
- jump_addr  in  ADDR_W  jump target
- out_ready  in  1  downstream (decoder side) can accept instruction
- instruction  out  8  fetched instruction; feeds `instruction_decoder.instruction`
- instr_valid  out  1  instruction/instr_pc hold a valid entry
- instr_pc  out  ADDR_W  address the current instruction was fetched from
- halted  out  1  high while in HALT
- busy  out  1  high while in RUN

Behaviour:
- **Reset** (rst=1 at an edge): state=IDLE, pc=0, instruction=8'h00, instr_valid=0, instr_pc=0, halted=0, busy=0.
  - Memory contents are NOT cleared by reset.
  - Reset mid-RUN or mid-HALT drops any pending instruction.
- **Memory:** 2**ADDR_W x 8 regs; write synchronous; read combinational at address pc.
- **Output register:** single entry.
  - transfer = instr_valid & out_ready.
  - advance = (state==RUN) & run & (!instr_valid | out_ready) & !jump_en.
- **IDLE:**
  - load_en writes memory.
  - run=1 -> RUN next cycle; pc keeps its current value.
  - No instruction is loaded in the cycle of the transition.
- **RUN:**
  - On advance: instruction<=mem[pc], instr_pc<=pc, instr_valid<=1, pc<=pc+1 (mod 2**ADDR_W; 0xFF -> 0x00 for ADDR_W=8).
  - If transfer occurs without advance: instr_valid<=0.
  - Stall: instr_valid=1 & out_ready=0 -> instruction, instr_pc and pc all held.
  - Jump (priority over advance): pc<=jump_addr, instr_valid<=0 (pending entry discarded even if out_ready=1 that cycle). The next advance fetches mem[jump_addr].
  - Halt on fetch: if advance and mem[pc]==HALT_OPCODE, the halt instruction is still loaded and valid, and state -> HALT.
  - run=0 while in RUN: no further advances; any held entry stays until transferred. Once instr_valid=0 (or in the same cycle its transfer happens), state -> IDLE.
  - load_en is ignored in RUN and HALT.
- **HALT:**
  - No advances; halted=1; held entry remains until transferred.
  - Leave to IDLE when run=0 and instr_valid=0. pc stays at the halt address+1.
  - jump_en is ignored in HALT.
- **Latency:** run rising in IDLE at edge N -> RUN after N; the first instruction is valid after edge N+1.
  - With out_ready held high, throughput is one instruction per cycle.
- **Simultaneous events:**
  - rst beats everything.
  - jump_en beats advance and halt detection.
  - transfer and advance in the same cycle leave instr_valid=1 with the new entry.
- **Outputs are registered:** busy=(state==RUN), halted=(state==HALT).

Test Plan:
- Load mem[0..3]=8'h00,8'h41,8'h82,8'hC3; run=1, out_ready=1 -> instruction sequence 00,41,82,C3 on consecutive cycles with instr_pc 0..3; decoder modes 0,1,2,3 one-hot in turn.
- Stall: out_ready=0 for 3 cycles while instruction=8'h41 valid -> instruction, instr_pc=1 and pc=2 held; resume -> 8'h82 next cycle with no skip or duplicate.
- Jump: jump_en=1, jump_addr=8'h10 while entry at pc 2 valid -> instr_valid=0 next cycle; following cycle instruction=mem[0x10], instr_pc=0x10.
- Halt/wrap: mem[0xFE]=8'h55, mem[0xFF]=8'h00, mem[0x00]=8'hFF; jump to 0xFE -> 55@FE, 00@FF, FF@00, then halted=1 with no further instructions; run=0 and transfer complete -> IDLE, pc=0x01.
- Load guard: load_en=1 with load_addr=0, load_data=8'hAA during RUN -> mem[0] unchanged; repeat in IDLE -> mem[0]=8'hAA on the next fetch.
- Reset mid-RUN with instr_valid=1 -> next cycle instr_valid=0, pc=0, busy=0, halted=0, and memory retains its program.
